// File: rtl/mem_read_responder_pkg.sv
// Shared types and defaults for the memory read responder and the cache fill
// logic that counts its data_valid responses.
package mem_read_responder_pkg;

    localparam int LATENCY_DEFAULT = 4;
    localparam int WORD_W          = 16;
    localparam int RESP_ADDR_W     = 16;

    typedef logic [WORD_W-1:0] word_t;

    // One response pipeline slot: a read in flight with its echoed address.
    typedef struct packed {
        logic                   valid;
        logic [RESP_ADDR_W-1:0] addr;
        word_t                  data;
    } resp_slot_t;

    localparam resp_slot_t RESP_SLOT_EMPTY = '{valid: 1'b0, addr: 16'h0000, data: 16'h0000};

endpackage

// File: rtl/mem_read_responder_resp_pipe.sv
// Fixed-latency response shift register. Each stage carries {valid, addr, data}.
// Address and data only advance alongside a valid slot, so the last stage keeps
// presenting the most recently delivered response through idle slots.
import mem_read_responder_pkg::*;

module mem_read_responder_resp_pipe #(
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  resp_slot_t in_slot,
    output resp_slot_t out_slot
);

    resp_slot_t stage_r [0:LATENCY-1];

    // Shift slots one stage per cycle; synchronous active-low clear empties every stage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_r[i] <= RESP_SLOT_EMPTY;
            end
        end else begin
            stage_r[0].valid <= in_slot.valid;
            if (in_slot.valid) begin
                stage_r[0].addr <= in_slot.addr;
                stage_r[0].data <= in_slot.data;
            end
            for (int i = 1; i < LATENCY; i++) begin
                stage_r[i].valid <= stage_r[i-1].valid;
                if (stage_r[i-1].valid) begin
                    stage_r[i].addr <= stage_r[i-1].addr;
                    stage_r[i].data <= stage_r[i-1].data;
                end
            end
        end
    end

    assign out_slot = stage_r[LATENCY-1];

endmodule

// File: rtl/mem_read_responder.sv
// Memory-side responder: writes commit on the issue cycle, reads snapshot the
// word on the issue cycle and return it LATENCY cycles later with its address.
import mem_read_responder_pkg::*;

module mem_read_responder #(
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int ADDR_W  = RESP_ADDR_W,
    parameter int DEPTH_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       data_in,
    output logic [15:0]       data_out,
    output logic              data_valid,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [3:0]        outstanding
);

    logic [WORD_W-1:0]  mem_r [0:(1<<DEPTH_W)-1];
    logic [DEPTH_W-1:0] word_idx_s;
    resp_slot_t         in_slot_s;
    resp_slot_t         out_slot_s;
    logic               rd_accept_s;
    logic               retire_s;
    logic [3:0]         outstanding_r;
    logic               unused_addr_bit_s;

    // Byte address bit 0 never selects anything; high bits alias by truncation.
    assign word_idx_s        = addr[DEPTH_W:1];
    assign unused_addr_bit_s = addr[0];
    assign rd_accept_s       = enable & ~wr;
    assign retire_s          = out_slot_s.valid;

    // Storage write port; requests seen while reset is low are discarded.
    always_ff @(posedge clk) begin
        if (rst && enable && wr) begin
            mem_r[word_idx_s] <= data_in;
        end
    end

    // Build the slot entering the pipeline: a read snapshots the word now.
    always_comb begin
        in_slot_s = RESP_SLOT_EMPTY;
        if (rd_accept_s) begin
            in_slot_s.valid = 1'b1;
            in_slot_s.addr  = {addr[ADDR_W-1:1], 1'b0};
            in_slot_s.data  = mem_r[word_idx_s];
        end else begin
            in_slot_s.valid = 1'b0;
        end
    end

    mem_read_responder_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_slot  (in_slot_s),
        .out_slot (out_slot_s)
    );

    // Count reads in flight: issue adds one, retirement removes one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding_r <= 4'h0;
        end else begin
            case ({rd_accept_s, retire_s})
                2'b10:   outstanding_r <= outstanding_r + 4'h1;
                2'b01:   outstanding_r <= outstanding_r - 4'h1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    assign data_valid  = out_slot_s.valid;
    assign data_out    = out_slot_s.data;
    assign resp_addr   = out_slot_s.addr;
    assign outstanding = outstanding_r;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench for mem_read_responder with LATENCY = 4.
module tb_mem_read_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [15:0] resp_addr;
    logic [3:0]  outstanding;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_read_responder #(
        .LATENCY (LAT),
        .ADDR_W  (16),
        .DEPTH_W (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .wr          (wr),
        .addr        (addr),
        .data_in     (data_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .resp_addr   (resp_addr),
        .outstanding (outstanding)
    );

    // Present one request, let the edge take it, and settle 1 ns after the edge.
    task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b0 || data_out !== 16'h0000 || resp_addr !== 16'h0000 || outstanding !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_state: dv=%b dout=%h raddr=%h outst=%0d, want 0/0000/0000/0",
                     data_valid, data_out, resp_addr, outstanding);
        end
        rst = 1'b1;
    endtask

    task automatic test_reset_midflight;
        step(1'b1, 1'b1, 16'h0050, 16'h1234);
        step(1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b1, 1'b0, 16'h0012, 16'h0000);
        n_cmp++;
        if (outstanding !== 4'h2) begin
            n_bad++;
            $display("FAIL midflight_outst_pre: got %0d want 2", outstanding);
        end
        // Reset cycle also carries a write that must be ignored.
        rst = 1'b0;
        step(1'b1, 1'b1, 16'h0050, 16'h9999);
        rst = 1'b1;
        n_cmp++;
        if (outstanding !== 4'h0 || data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL midflight_after_rst: outst=%0d dv=%b want 0/0", outstanding, data_valid);
        end
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0, 16'h0000, 16'h0000);
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL midflight_no_dv: step %0d got dv=%b want 0", k, data_valid);
            end
        end
        step(1'b1, 1'b0, 16'h0050, 16'h0000);
        for (int k = 1; k < LAT; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'h1234) begin
            n_bad++;
            $display("FAIL reset_write_ignored: dv=%b dout=%h want 1/1234", data_valid, data_out);
        end
    endtask

    task automatic test_write_then_read;
        step(1'b1, 1'b1, 16'h0040, 16'hBEEF);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int k = 1; k < LAT; k++) begin
            n_cmp++;
            if (data_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_rd_early_dv: k=%0d got dv=%b want 0", k, data_valid);
            end
            step(1'b0, 1'b0, 16'h0000, 16'h0000);
        end
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'hBEEF || resp_addr !== 16'h0040) begin
            n_bad++;
            $display("FAIL wr_rd_resp: dv=%b dout=%h raddr=%h want 1/beef/0040", data_valid, data_out, resp_addr);
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b0 || data_out !== 16'hBEEF || outstanding !== 4'h0) begin
            n_bad++;
            $display("FAIL wr_rd_after: dv=%b dout=%h outst=%0d want 0/beef/0", data_valid, data_out, outstanding);
        end
    endtask

    task automatic test_snapshot;
        step(1'b1, 1'b1, 16'h0040, 16'h1111);
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        step(1'b1, 1'b1, 16'h0040, 16'h2222);
        for (int k = 2; k < LAT; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'h1111) begin
            n_bad++;
            $display("FAIL snapshot_old: dv=%b dout=%h want 1/1111", data_valid, data_out);
        end
        step(1'b1, 1'b0, 16'h0040, 16'h0000);
        for (int k = 1; k < LAT; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'h2222) begin
            n_bad++;
            $display("FAIL snapshot_new: dv=%b dout=%h want 1/2222", data_valid, data_out);
        end
    endtask

    task automatic test_back_to_back;
        int          pulses;
        int          peak;
        int          idx;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
        pulses = 0;
        peak   = 0;
        for (int i = 0; i < 8; i++) begin
            exp_a = 16'h0100 + 16'(2 * i);
            exp_d = 16'hC000 + 16'(i);
            step(1'b1, 1'b1, exp_a, exp_d);
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int s = 0; s < 8 + LAT; s++) begin
            if (s < 8) begin
                exp_a = 16'h0100 + 16'(2 * s);
                step(1'b1, 1'b0, exp_a, 16'h0000);
            end else begin
                step(1'b0, 1'b0, 16'h0000, 16'h0000);
            end
            if (int'(outstanding) > peak) peak = int'(outstanding);
            idx = s - (LAT - 1);
            if (idx >= 0 && idx < 8) begin
                exp_a = 16'h0100 + 16'(2 * idx);
                exp_d = 16'hC000 + 16'(idx);
                n_cmp++;
                if (data_valid !== 1'b1 || data_out !== exp_d || resp_addr !== exp_a) begin
                    n_bad++;
                    $display("FAIL burst_resp: beat %0d dv=%b dout=%h raddr=%h want 1/%h/%h",
                             idx, data_valid, data_out, resp_addr, exp_d, exp_a);
                end
            end
            if (data_valid === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 8) begin
            n_bad++;
            $display("FAIL burst_pulses: got %0d want 8", pulses);
        end
        n_cmp++;
        if (peak != LAT) begin
            n_bad++;
            $display("FAIL burst_peak_outst: got %0d want %0d", peak, LAT);
        end
        n_cmp++;
        if (outstanding !== 4'h0) begin
            n_bad++;
            $display("FAIL burst_final_outst: got %0d want 0", outstanding);
        end
    endtask

    task automatic test_gapped;
        logic        exp_v [0:7];
        logic [15:0] exp_d [0:7];
        logic [15:0] exp_a [0:7];
        exp_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_d = '{16'h0000, 16'h0000, 16'h0000, 16'h3A01, 16'h3A01, 16'h3A02, 16'h3A03, 16'h3A03};
        exp_a = '{16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0200, 16'h0202, 16'h0204, 16'h0204};
        step(1'b1, 1'b1, 16'h0200, 16'h3A01);
        step(1'b1, 1'b1, 16'h0202, 16'h3A02);
        step(1'b1, 1'b1, 16'h0204, 16'h3A03);
        for (int s = 0; s < 8; s++) begin
            case (s)
                0:       step(1'b1, 1'b0, 16'h0200, 16'h0000);
                2:       step(1'b1, 1'b0, 16'h0202, 16'h0000);
                3:       step(1'b1, 1'b0, 16'h0204, 16'h0000);
                default: step(1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
            n_cmp++;
            if (data_valid !== exp_v[s] ||
                (s >= LAT - 1 && (data_out !== exp_d[s] || resp_addr !== exp_a[s]))) begin
                n_bad++;
                $display("FAIL gapped: step %0d dv=%b dout=%h raddr=%h want %b/%h/%h",
                         s, data_valid, data_out, resp_addr, exp_v[s], exp_d[s], exp_a[s]);
            end
        end
    endtask

    task automatic test_addr_bit0;
        step(1'b1, 1'b1, 16'h0003, 16'hA5A5);
        step(1'b1, 1'b0, 16'h0002, 16'h0000);
        step(1'b1, 1'b0, 16'h0003, 16'h0000);
        for (int k = 2; k < LAT; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'hA5A5 || resp_addr !== 16'h0002) begin
            n_bad++;
            $display("FAIL addr0_even: dv=%b dout=%h raddr=%h want 1/a5a5/0002", data_valid, data_out, resp_addr);
        end
        step(1'b0, 1'b0, 16'h0000, 16'h0000);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 16'hA5A5 || resp_addr !== 16'h0002) begin
            n_bad++;
            $display("FAIL addr0_odd: dv=%b dout=%h raddr=%h want 1/a5a5/0002", data_valid, data_out, resp_addr);
        end
    endtask

    initial begin
        rst     = 1'b0;
        enable  = 1'b0;
        wr      = 1'b0;
        addr    = 16'h0000;
        data_in = 16'h0000;
        test_reset();
        test_reset_midflight();
        test_write_then_read();
        test_snapshot();
        test_back_to_back();
        test_gapped();
        test_addr_bit0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
